attn_inst_sequencer: RTL

- Autonomous instruction sequencer that sits directly upstream of fullchip and drives its 19-bit inst bus.
- After the host has written Qmem/Kmem (host instructions pass through while idle), one start pulse triggers the full hardware sequence with no host involvement: K load, Q execute, ofifo→pmem move, and per-row sfp accumulate/divide.
- It also emits sample strobes so downstream capture logic knows when sum_out and out are valid.

---
 rtl/attn_inst_sequencer_pkg.sv | 62 ++++++
 rtl/attn_inst_sequencer_if.sv | 39 +++
 rtl/attn_inst_sequencer_inst_pack.sv | 32 +++
 rtl/attn_inst_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_inst_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// attn_pkg
// Shared definitions for the attention instruction sequencer:
//   - bit positions of every field in the 19-bit fullchip instruction word
//   - sequencer state enumeration
//   - SFP sub-cycle encodings (five sub-cycles per pmem row)
//   - inst_fields_t, the unpacked view of an instruction consumed by inst_pack
// -----------------------------------------------------------------------------
package attn_pkg;

   localparam int INST_W       = 19;
   localparam int FA_W         = 4;   // width of qkmem_add / pmem_add fields

   localparam int DIV_B        = 18;
   localparam int ACC_B        = 17;
   localparam int OFIFO_RD_B   = 16;
   localparam int QK_ADD_LSB   = 12;
   localparam int PMEM_ADD_LSB = 8;
   localparam int EXEC_B       = 7;
   localparam int LOAD_B       = 6;
   localparam int QMEM_RD_B    = 5;
   localparam int QMEM_WR_B    = 4;
   localparam int KMEM_RD_B    = 3;
   localparam int KMEM_WR_B    = 2;
   localparam int PMEM_RD_B    = 1;
   localparam int PMEM_WR_B    = 0;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      GAP1,
      EXEC,
      GAP2,
      MOVE,
      SFP,
      TAIL,
      DONE
   } state_t;

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;

   typedef struct packed {
      logic            div_ready;
      logic            acc_ready;
      logic            ofifo_rd;
      logic [FA_W-1:0] qkmem_add;
      logic [FA_W-1:0] pmem_add;
      logic            execute;
      logic            load;
      logic            qmem_rd;
      logic            qmem_wr;
      logic            kmem_rd;
      logic            kmem_wr;
      logic            pmem_rd;
      logic            pmem_wr;
   } inst_fields_t;

endpackage

// File: rtl/attn_inst_sequencer_if.sv
// -----------------------------------------------------------------------------
// attn_inst_sequencer_if
// Host/control bundle of the sequencer.
//   start      host -> seq   one-cycle start request
//   host_inst  host -> seq   instruction passed through while idle
//   inst       seq  -> chip  registered fullchip instruction word
//   busy       seq  -> host  sequence in progress
//   done       seq  -> host  one-cycle end-of-sequence pulse
//   sum_valid  seq  -> cap   sum_out1/2 valid this cycle
//   out_valid  seq  -> cap   out1/2 valid this cycle
//   row_idx    seq  -> cap   row the valid strobes refer to
// master: host/capture side; slave: the sequencer.
// -----------------------------------------------------------------------------
interface attn_inst_sequencer_if
   import attn_pkg::*;
#(
   parameter int ADDR_W = 4
) ();

   logic              start;
   logic [INST_W-1:0] host_inst;
   logic [INST_W-1:0] inst;
   logic              busy;
   logic              done;
   logic              sum_valid;
   logic              out_valid;
   logic [ADDR_W-1:0] row_idx;

   modport master (
      output start, host_inst,
      input  inst, busy, done, sum_valid, out_valid, row_idx
   );

   modport slave (
      input  start, host_inst,
      output inst, busy, done, sum_valid, out_valid, row_idx
   );

endinterface

// File: rtl/attn_inst_sequencer_inst_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational: packs the individual instruction fields into the
// 19-bit fullchip instruction word.
//   i_fields  in   field values
//   o_inst    out  packed instruction word
// -----------------------------------------------------------------------------
module inst_pack
   import attn_pkg::*;
(
   input  inst_fields_t      i_fields,
   output logic [INST_W-1:0] o_inst
);

   always_comb begin
      o_inst                            = '0;
      o_inst[DIV_B]                     = i_fields.div_ready;
      o_inst[ACC_B]                     = i_fields.acc_ready;
      o_inst[OFIFO_RD_B]                = i_fields.ofifo_rd;
      o_inst[QK_ADD_LSB +: FA_W]        = i_fields.qkmem_add;
      o_inst[PMEM_ADD_LSB +: FA_W]      = i_fields.pmem_add;
      o_inst[EXEC_B]                    = i_fields.execute;
      o_inst[LOAD_B]                    = i_fields.load;
      o_inst[QMEM_RD_B]                 = i_fields.qmem_rd;
      o_inst[QMEM_WR_B]                 = i_fields.qmem_wr;
      o_inst[KMEM_RD_B]                 = i_fields.kmem_rd;
      o_inst[KMEM_WR_B]                 = i_fields.kmem_wr;
      o_inst[PMEM_RD_B]                 = i_fields.pmem_rd;
      o_inst[PMEM_WR_B]                 = i_fields.pmem_wr;
   end

endmodule

// File: rtl/attn_inst_sequencer.sv
// -----------------------------------------------------------------------------
// attn_inst_sequencer
// Drives the fullchip instruction bus. While idle the host instruction is
// passed through with one cycle of latency; a start pulse runs the complete
// K-load / Q-execute / ofifo->pmem move / SFP accumulate-divide sequence and
// raises sample strobes for the downstream capture logic.
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high
//   bus    slave modport of attn_inst_sequencer_if (start, host_inst in;
//          inst, busy, done, sum_valid, out_valid, row_idx out)
// Every output is a register loaded from the decode of the *next* state, so
// the outputs line up with the state the sequencer is in during that cycle.
// -----------------------------------------------------------------------------
module attn_inst_sequencer
   import attn_pkg::*;
#(
   parameter int COL         = 8,
   parameter int TOTAL_CYCLE = 8,
   parameter int GAP_CYCLES  = 10,
   parameter int ADDR_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   attn_inst_sequencer_if.slave  bus
);

   localparam int CNT_W = 16;

   localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(COL + 2);
   localparam logic [CNT_W-1:0]  COL_C     = CNT_W'(COL);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TOTAL_CYCLE);   // drain cycle index
   localparam logic [CNT_W-1:0]  TAIL_LAST = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(TOTAL_CYCLE - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]  r_row;
   logic [2:0]         r_sub;
   logic [INST_W-1:0]  r_inst;
   logic               r_busy;
   logic               r_done;
   logic               r_sum_valid;
   logic               r_out_valid;
   logic [ADDR_W-1:0]  r_row_idx;

   state_t             w_nstate;
   logic [CNT_W-1:0]   w_ncnt;
   logic [ADDR_W-1:0]  w_nrow;
   logic [2:0]         w_nsub;
   inst_fields_t       w_fields;
   logic [INST_W-1:0]  w_packed;
   logic [INST_W-1:0]  w_ninst;
   logic               w_nbusy;
   logic               w_ndone;
   logic               w_nsum_valid;
   logic               w_nout_valid;
   logic [ADDR_W-1:0]  w_nrow_idx;

   // Next-state and phase counters; every phase starts its counter at 0.
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt + CNT_W'(1);
      w_nrow   = r_row;
      w_nsub   = r_sub;
      case (r_state)
         IDLE: begin
            w_ncnt = '0;
            if (bus.start) w_nstate = LOAD;
         end
         LOAD: begin
            if (r_cnt == LOAD_LAST) begin
               w_nstate = (GAP_CYCLES > 0) ? GAP1 : EXEC;
               w_ncnt   = '0;
            end
         end
         GAP1: begin
            if (r_cnt == GAP_LAST) begin
               w_nstate = EXEC;
               w_ncnt   = '0;
            end
         end
         EXEC: begin
            if (r_cnt == RUN_LAST) begin
               w_nstate = (GAP_CYCLES > 0) ? GAP2 : MOVE;
               w_ncnt   = '0;
            end
         end
         GAP2: begin
            if (r_cnt == GAP_LAST) begin
               w_nstate = MOVE;
               w_ncnt   = '0;
            end
         end
         MOVE: begin
            if (r_cnt == RUN_LAST) begin
               w_nstate = SFP;
               w_ncnt   = '0;
               w_nrow   = '0;
               w_nsub   = S0;
            end
         end
         SFP: begin
            w_ncnt = '0;
            if (r_sub == S4) begin
               w_nsub = S0;
               if (r_row == ROW_LAST) begin
                  w_nstate = TAIL;
                  w_nrow   = '0;
               end else begin
                  w_nrow = r_row + ADDR_W'(1);
               end
            end else begin
               w_nsub = r_sub + 3'd1;
            end
         end
         TAIL: begin
            if (r_cnt == TAIL_LAST) begin
               w_nstate = DONE;
               w_ncnt   = '0;
            end
         end
         DONE: begin
            w_nstate = IDLE;
            w_ncnt   = '0;
         end
         default: begin
            w_nstate = IDLE;
            w_ncnt   = '0;
         end
      endcase
   end

   // Output decode of the state being entered.
   always_comb begin
      w_fields     = '0;
      w_nbusy      = 1'b0;
      w_ndone      = 1'b0;
      w_nsum_valid = 1'b0;
      w_nout_valid = 1'b0;
      w_nrow_idx   = '0;
      case (w_nstate)
         LOAD: begin
            w_nbusy       = 1'b1;
            w_fields.load = (w_ncnt != LOAD_LAST);
            if ((w_ncnt >= CNT_W'(1)) && (w_ncnt <= COL_C)) begin
               w_fields.kmem_rd   = 1'b1;
               w_fields.qkmem_add = FA_W'(w_ncnt - CNT_W'(1));
            end
         end
         GAP1, GAP2: begin
            w_nbusy = 1'b1;
         end
         EXEC: begin
            w_nbusy = 1'b1;
            if (w_ncnt < RUN_LAST) begin
               w_fields.execute   = 1'b1;
               w_fields.qmem_rd   = 1'b1;
               w_fields.qkmem_add = FA_W'(w_ncnt);
            end
         end
         MOVE: begin
            w_nbusy = 1'b1;
            if (w_ncnt < RUN_LAST) begin
               w_fields.ofifo_rd = 1'b1;
               w_fields.pmem_wr  = 1'b1;
               w_fields.pmem_add = FA_W'(w_ncnt);
            end
         end
         SFP: begin
            w_nbusy            = 1'b1;
            w_fields.pmem_rd   = 1'b1;
            w_fields.pmem_add  = FA_W'(w_nrow);
            w_fields.acc_ready = (w_nsub == S1) || (w_nsub == S2);
            w_fields.div_ready = (w_nsub == S3) || (w_nsub == S4);
            if (w_nsub == S3) begin
               w_nsum_valid = 1'b1;
               w_nrow_idx   = w_nrow;
            end
            // out of the previous row becomes valid as the next row starts
            if ((w_nsub == S0) && (w_nrow != '0)) begin
               w_nout_valid = 1'b1;
               w_nrow_idx   = w_nrow - ADDR_W'(1);
            end
         end
         TAIL: begin
            w_nbusy            = 1'b1;
            w_fields.div_ready = 1'b1;
         end
         DONE: begin
            w_ndone      = 1'b1;
            w_nout_valid = 1'b1;
            w_nrow_idx   = ROW_LAST;
         end
         default: begin
            w_nbusy = 1'b0;
         end
      endcase
   end

   inst_pack u_inst_pack (
      .i_fields (w_fields),
      .o_inst   (w_packed)
   );

   assign w_ninst = (w_nstate == IDLE) ? bus.host_inst : w_packed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_row       <= '0;
         r_sub       <= S0;
         r_inst      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sum_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_row_idx   <= '0;
      end else begin
         r_state     <= w_nstate;
         r_cnt       <= w_ncnt;
         r_row       <= w_nrow;
         r_sub       <= w_nsub;
         r_inst      <= w_ninst;
         r_busy      <= w_nbusy;
         r_done      <= w_ndone;
         r_sum_valid <= w_nsum_valid;
         r_out_valid <= w_nout_valid;
         r_row_idx   <= w_nrow_idx;
      end
   end

   assign bus.inst      = r_inst;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.sum_valid = r_sum_valid;
   assign bus.out_valid = r_out_valid;
   assign bus.row_idx   = r_row_idx;

endmodule
